// File: rtl/experiment_sequencer.sv
// Experiment sequencer: start/fast-gate aligned detonation, debounced wire confirm, detector trigger.
// Optional build macro EXP_TIMESTAMP_EN adds the wire_latency / wire_latency_valid outputs.
module experiment_sequencer #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned N_DET        = 4,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned DET_PULSE    = 400,
    parameter int unsigned TRIG_PULSE   = 40,
    parameter int unsigned WIRE_TIMEOUT = 400000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_signal,
    input  logic             fg_signal,
    input  logic             wire_signal,
    input  logic [N_DET-1:0] detector_ready,
    input  logic [N_DET-1:0] det_mask,
    input  logic             phase_shift,
    input  logic [CNT_W-1:0] fg_delay,
    output logic             detonation_signal,
    output logic             output_trigger,
    output logic [2:0]       scenario_state,
    output logic [CNT_W-1:0] counter_,
    output logic             fault
`ifdef EXP_TIMESTAMP_EN
    ,
    output logic [CNT_W-1:0] wire_latency,
    output logic             wire_latency_valid
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMED     = 3'd1,
        S_FG_DELAY  = 3'd2,
        S_DETONATE  = 3'd3,
        S_WAIT_WIRE = 3'd4,
        S_TRIGGER   = 3'd5,
        S_WAIT_DET  = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam int unsigned      DEB_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DET_LAST  = CNT_W'(DET_PULSE - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_PULSE - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(WIRE_TIMEOUT);
    localparam logic [DEB_W-1:0] DEB_DONE  = DEB_W'(DEBOUNCE_CYC);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [DEB_W-1:0] r_deb;

    logic             r_start_s1, r_start_s2, r_start_d;
    logic             r_fg_s1, r_fg_s2, r_fg_d;
    logic             r_wire_s1, r_wire_s2;
    logic [N_DET-1:0] r_rdy_s1, r_rdy_s2;

    logic w_start_rise, w_fg_edge, w_ready_all, w_wire_ok;

    // Synchronisers carry no reset so a pin held high across reset cannot fake an edge.
    always_ff @(posedge clock) begin
        r_start_s1 <= start_signal;
        r_start_s2 <= r_start_s1;
        r_start_d  <= r_start_s2;
        r_fg_s1    <= fg_signal;
        r_fg_s2    <= r_fg_s1;
        r_fg_d     <= r_fg_s2;
        r_wire_s1  <= wire_signal;
        r_wire_s2  <= r_wire_s1;
        r_rdy_s1   <= detector_ready;
        r_rdy_s2   <= r_rdy_s1;
    end

    assign w_start_rise = r_start_s2 & ~r_start_d;
    assign w_fg_edge    = phase_shift ? (~r_fg_s2 & r_fg_d) : (r_fg_s2 & ~r_fg_d);
    assign w_ready_all  = &(r_rdy_s2 | ~det_mask);
    assign w_wire_ok    = (r_deb == DEB_DONE);

    always_ff @(posedge clock) begin
        if (reset || r_state != S_WAIT_WIRE || !r_wire_s2)
            r_deb <= '0;
        else if (r_deb != DEB_DONE)
            r_deb <= r_deb + DEB_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Down-counting states leave on the cycle the counter lands on zero, not one cycle after.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start_rise && w_ready_all) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                w_cnt_nxt = '0;
                if (!w_ready_all) begin
                    w_state_nxt = S_FAULT;
                end else if (w_fg_edge) begin
                    w_state_nxt = S_FG_DELAY;
                    w_cnt_nxt   = fg_delay;
                end
            end
            S_FG_DELAY: begin
                if (!w_ready_all) begin
                    w_state_nxt = S_FAULT;
                    w_cnt_nxt   = '0;
                end else begin
                    if (r_cnt <= CNT_ONE) w_state_nxt = S_DETONATE;
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_DETONATE: begin
                if (r_cnt == DET_LAST) begin
                    w_state_nxt = S_WAIT_WIRE;
                    w_cnt_nxt   = TMO_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_WAIT_WIRE: begin
                if (w_wire_ok) begin
                    w_state_nxt = S_TRIGGER;
                    w_cnt_nxt   = '0;
                end else if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_FAULT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_TRIGGER: begin
                if (r_cnt == TRIG_LAST) begin
                    w_state_nxt = S_WAIT_DET;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_WAIT_DET: begin
                if (w_ready_all) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_FAULT: w_cnt_nxt = '0;
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign detonation_signal = (r_state == S_DETONATE);
    assign output_trigger    = (r_state == S_TRIGGER);
    assign fault             = (r_state == S_FAULT);
    assign scenario_state    = r_state;
    assign counter_          = r_cnt;

`ifdef EXP_TIMESTAMP_EN
    logic [CNT_W-1:0] r_ts;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts               <= '0;
            wire_latency       <= '0;
            wire_latency_valid <= 1'b0;
        end else begin
            wire_latency_valid <= 1'b0;
            if (r_state == S_DETONATE && w_state_nxt == S_WAIT_WIRE)
                r_ts <= '0;
            else if (r_ts != '1)
                r_ts <= r_ts + CNT_ONE;
            if (r_state == S_WAIT_WIRE && w_state_nxt == S_TRIGGER) begin
                wire_latency       <= r_ts;
                wire_latency_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_experiment_sequencer.sv
// Scoreboard bench for experiment_sequencer: stimulus queues timed output events, a monitor matches them.
`timescale 1ns/1ps
module tb_experiment_sequencer;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned N_DET = 4;
    localparam int WT = 1000;

    localparam int K_ARM = 0, K_DETR = 1, K_DETF = 2, K_TRGR = 3, K_TRGF = 4, K_FAULT = 5, K_IDLE = 6;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start_signal = 1'b0;
    logic             fg_signal = 1'b0;
    logic             wire_signal = 1'b0;
    logic [N_DET-1:0] detector_ready = '1;
    logic [N_DET-1:0] det_mask = '1;
    logic             phase_shift = 1'b0;
    logic [CNT_W-1:0] fg_delay = 32'd100;
    logic             detonation_signal, output_trigger, fault;
    logic [2:0]       scenario_state;
    logic [CNT_W-1:0] counter_;
`ifdef EXP_TIMESTAMP_EN
    logic [CNT_W-1:0] wire_latency;
    logic             wire_latency_valid;
`endif

    always #5 clock = ~clock;

    experiment_sequencer #(
        .CNT_W(CNT_W), .N_DET(N_DET), .DEBOUNCE_CYC(16),
        .DET_PULSE(400), .TRIG_PULSE(40), .WIRE_TIMEOUT(WT)
    ) dut (
        .clock(clock), .reset(reset), .start_signal(start_signal), .fg_signal(fg_signal),
        .wire_signal(wire_signal), .detector_ready(detector_ready), .det_mask(det_mask),
        .phase_shift(phase_shift), .fg_delay(fg_delay), .detonation_signal(detonation_signal),
        .output_trigger(output_trigger), .scenario_state(scenario_state), .counter_(counter_),
        .fault(fault)
`ifdef EXP_TIMESTAMP_EN
        , .wire_latency(wire_latency), .wire_latency_valid(wire_latency_valid)
`endif
    );

    typedef struct { int kind; int cyc; } ev_t;
    ev_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0, n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_ARM:   return "ARM";
            K_DETR:  return "DET_RISE";
            K_DETF:  return "DET_FALL";
            K_TRGR:  return "TRG_RISE";
            K_TRGF:  return "TRG_FALL";
            K_FAULT: return "FAULT_RISE";
            K_IDLE:  return "IDLE_ENTRY";
            default: return "UNKNOWN";
        endcase
    endfunction

    task automatic expect_ev(input int k, input int c);
        exp_q.push_back('{kind: k, cyc: c});
    endtask

    task automatic got(input int k);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required no event", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL ev_%s: got %s at cycle %0d, required %s at cycle %0d",
                         kname(e.kind), kname(k), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: turns output transitions into events and checks them against the queue
    logic       p_det = 1'b0, p_trg = 1'b0, p_flt = 1'b0;
    logic [2:0] p_st = 3'd0;
    bit         mon_en = 1'b0;

    always @(negedge clock) begin
        if (mon_en) begin
            if (!detonation_signal && p_det) got(K_DETF);
            if (detonation_signal && !p_det) got(K_DETR);
            if (!output_trigger && p_trg)    got(K_TRGF);
            if (output_trigger && !p_trg)    got(K_TRGR);
            if (fault && !p_flt)             got(K_FAULT);
            if (scenario_state == 3'd0 && p_st != 3'd0) got(K_IDLE);
            if (scenario_state == 3'd1 && p_st != 3'd1) got(K_ARM);
        end
        p_det = detonation_signal;
        p_trg = output_trigger;
        p_flt = fault;
        p_st  = scenario_state;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic arm();
        @(negedge clock);
        start_signal = 1'b1;
        expect_ev(K_ARM, cyc + 3);
        tick(4);
        start_signal = 1'b0;
        tick(4);
    endtask

    task automatic do_reset(input bit leaves_busy);
        @(negedge clock);
        reset = 1'b1;
        if (leaves_busy) expect_ev(K_IDLE, cyc + 1);
        @(negedge clock);
        reset = 1'b0;
        chk("reset_state", scenario_state, 0);
        chk("reset_fault", fault, 0);
        tick(5);
    endtask

    task automatic fire_fg(output int tf);
        @(negedge clock);
        fg_signal = ~phase_shift;
        tf = cyc;
    endtask

    // Wire confirm after detonation ends at cycle e; optional bounce before going stable
    task automatic finish_shot(input int e, input bit bounce);
        int bt[10] = '{10, 40, 12, 100, 11, 25, 12, 60, 10, 30};
        int tw;
        wait_cyc(e + 3);
        if (bounce) begin
            for (int i = 0; i < 10; i++) begin
                wire_signal = (i % 2 == 0);
                tick(bt[i]);
            end
        end
        wire_signal = 1'b1;
        tw = cyc;
        expect_ev(K_TRGR, tw + 19);
        expect_ev(K_TRGF, tw + 59);
        expect_ev(K_IDLE, tw + 60);
        wait_cyc(tw + 65);
        chk("idle_after_shot", scenario_state, 0);
        chk("idle_counter", counter_, 0);
        wire_signal = 1'b0;
        fg_signal   = 1'b0;
        tick(6);
    endtask

    initial begin
        int tf, td, tr, e;
        tick(5);
        chk("rst_state", scenario_state, 0);
        chk("rst_counter", counter_, 0);
        chk("rst_det", detonation_signal, 0);
        chk("rst_trig", output_trigger, 0);
        chk("rst_fault", fault, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(5);

        // Nominal shot with wire bounce
        arm();
        chk("armed_counter", counter_, 0);
        fire_fg(tf);
        expect_ev(K_DETR, tf + 103);
        expect_ev(K_DETF, tf + 503);
        wait_cyc(tf + 3);
        chk("fgdelay_load", counter_, 100);
        chk("fgdelay_state", scenario_state, 2);
        wait_cyc(tf + 4);
        chk("fgdelay_dec", counter_, 99);
        wait_cyc(tf + 503);
        chk("timeout_load", counter_, WT);
        chk("wait_wire_state", scenario_state, 4);
        finish_shot(tf + 503, 1'b1);

        // Falling-edge alignment; rising edge ignored
        phase_shift = 1'b1;
        arm();
        @(negedge clock);
        fg_signal = 1'b1;
        tick(30);
        fire_fg(tf);
        expect_ev(K_DETR, tf + 103);
        expect_ev(K_DETF, tf + 503);
        finish_shot(tf + 503, 1'b0);
        phase_shift = 1'b0;

        // Masked-in detector drops during FG_DELAY
        arm();
        fire_fg(tf);
        wait_cyc(tf + 20);
        detector_ready[2] = 1'b0;
        td = cyc;
        expect_ev(K_FAULT, td + 3);
        wait_cyc(tf + 150);
        chk("dropout_state", scenario_state, 7);
        chk("dropout_fault", fault, 1);
        chk("dropout_det", detonation_signal, 0);
        detector_ready[2] = 1'b1;
        fg_signal = 1'b0;
        tick(3);
        do_reset(1'b1);

        // Same dropout with channel 2 masked out
        det_mask = 4'hB;
        arm();
        fire_fg(tf);
        expect_ev(K_DETR, tf + 103);
        expect_ev(K_DETF, tf + 503);
        wait_cyc(tf + 20);
        detector_ready[2] = 1'b0;
        finish_shot(tf + 503, 1'b0);
        detector_ready[2] = 1'b1;
        det_mask = 4'hF;
        tick(4);

        // Wire never arrives
        arm();
        fire_fg(tf);
        e = tf + 503;
        expect_ev(K_DETR, tf + 103);
        expect_ev(K_DETF, e);
        expect_ev(K_FAULT, e + WT);
        wait_cyc(e + WT + 5);
        chk("timeout_state", scenario_state, 7);
        chk("timeout_fault", fault, 1);
        fg_signal = 1'b0;
        do_reset(1'b1);

        // Wire debounced exactly on the timeout cycle wins
        arm();
        fire_fg(tf);
        e = tf + 503;
        expect_ev(K_DETR, tf + 103);
        expect_ev(K_DETF, e);
        wait_cyc(e + WT - 19);
        wire_signal = 1'b1;
        expect_ev(K_TRGR, e + WT);
        expect_ev(K_TRGF, e + WT + 40);
        expect_ev(K_IDLE, e + WT + 41);
        wait_cyc(e + WT + 46);
        chk("lastcycle_fault", fault, 0);
        chk("lastcycle_state", scenario_state, 0);
        wire_signal = 1'b0;
        fg_signal = 1'b0;
        tick(6);

        // Zero delay: detonation the cycle after FG_DELAY entry
        fg_delay = '0;
        arm();
        fire_fg(tf);
        expect_ev(K_DETR, tf + 4);
        expect_ev(K_DETF, tf + 404);
        finish_shot(tf + 404, 1'b0);
        fg_delay = 32'd100;

        // Reset in the middle of the detonation pulse
        arm();
        fire_fg(tf);
        expect_ev(K_DETR, tf + 103);
        wait_cyc(tf + 153);
        reset = 1'b1;
        tr = cyc;
        expect_ev(K_DETF, tr + 1);
        expect_ev(K_IDLE, tr + 1);
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_det", detonation_signal, 0);
        chk("midrst_state", scenario_state, 0);
        chk("midrst_counter", counter_, 0);
        fg_signal = 1'b0;
        tick(5);

        // Start ignored while a masked-in detector is not ready
        detector_ready[0] = 1'b0;
        tick(4);
        start_signal = 1'b1;
        tick(4);
        start_signal = 1'b0;
        tick(20);
        chk("notready_idle", scenario_state, 0);
        detector_ready[0] = 1'b1;
        tick(4);
        arm();
        chk("armed_state", scenario_state, 1);
        start_signal = 1'b1;
        tick(4);
        start_signal = 1'b0;
        tick(6);
        chk("armed_restart_ignored", scenario_state, 1);
        do_reset(1'b1);

        tick(10);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            foreach (exp_q[i])
                $display("FAIL missing_event: got nothing, required %s at cycle %0d",
                         kname(exp_q[i].kind), exp_q[i].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
        $fatal(1);
    end

endmodule
